// File: rtl/wb_stage_pipe_pkg.sv
// Shared definitions for the writeback stage, MEM stage and load unit:
// FSM states, load funct3 encodings and the legal datapath widths.
package wb_stage_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DRAIN    = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  function automatic logic xlen_legal(input int xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-to-writeback bundle: instruction handshake, memory response, flush and
// the registered writeback/retire outputs. dbg_state mirrors the stage FSM.
interface wb_stage_pipe_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
);
    import wb_stage_pipe_pkg::*;
    localparam int OFF_W = $clog2(XLEN / 8);

    // An instruction transfers on a rising edge where in_valid & in_ready & ~flush;
    // in_valid may be raised independently of in_ready and in_ready depends only on state.
    logic              in_valid;
    logic              in_ready;
    logic              in_mem_read;
    logic              in_jump;
    logic [2:0]        in_funct3;
    logic [OFF_W-1:0]  in_addr_lo;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_alu_result;
    logic [XLEN-1:0]   in_pc_incre;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_data;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [CNT_W-1:0]  retire_cnt;
    wb_state_e         dbg_state;

    modport master (
        output in_valid, in_mem_read, in_jump, in_funct3, in_addr_lo, in_rd,
               in_alu_result, in_pc_incre, mem_rsp_valid, mem_rsp_data, flush,
        input  in_ready, wb_en, wb_rd, wb_data, retire_cnt, dbg_state
    );

    modport slave (
        input  in_valid, in_mem_read, in_jump, in_funct3, in_addr_lo, in_rd,
               in_alu_result, in_pc_incre, mem_rsp_valid, mem_rsp_data, flush,
        output in_ready, wb_en, wb_rd, wb_data, retire_cnt, dbg_state
    );

endinterface

// File: rtl/wb_stage_pipe_load_extract.sv
// Combinational sub-word load extraction: align raw word by byte offset, then
// sign- or zero-extend to XLEN. Also used by the forwarding path.
module load_extract
    import wb_stage_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_raw,
    input  logic [2:0]       i_funct3,
    input  logic [OFF_W-1:0] i_offset,
    output logic [XLEN-1:0]  o_data
);

    logic [1:0]       w_size;      // log2 of access size in bytes
    logic             w_signed;
    logic [OFF_W-1:0] w_off_mask;
    logic [OFF_W-1:0] w_eff_off;
    logic [XLEN-1:0]  w_shifted;
    logic [6:0]       w_nbits;
    logic [XLEN-1:0]  w_ext_mask;
    logic             w_sign;

    always_comb begin
        w_size   = 2'd3;
        w_signed = 1'b0;
        case (i_funct3)
            F3_LB:   begin w_size = 2'd0; w_signed = 1'b1; end
            F3_LH:   begin w_size = 2'd1; w_signed = 1'b1; end
            F3_LW:   begin w_size = 2'd2; w_signed = 1'b1; end
            F3_LBU:  w_size = 2'd0;
            F3_LHU:  w_size = 2'd1;
            F3_LWU:  w_size = 2'd2;
            default: w_size = 2'd3;
        endcase
        // On a 32-bit datapath every word-or-larger access is simply the full word.
        if ((XLEN == XLEN_32) && (w_size == 2'd3)) w_size = 2'd2;

        w_off_mask = {OFF_W{1'b1}} << w_size;
        w_eff_off  = i_offset & w_off_mask;
        w_shifted  = i_raw >> {w_eff_off, 3'b000};
        w_nbits    = 7'd8 << w_size;
        w_ext_mask = ~({XLEN{1'b1}} << w_nbits);

        case (w_size)
            2'd0:    w_sign = w_signed & w_shifted[7];
            2'd1:    w_sign = w_signed & w_shifted[15];
            2'd2:    w_sign = w_signed & w_shifted[31];
            default: w_sign = 1'b0;
        endcase

        o_data = (w_shifted & w_ext_mask) | ({XLEN{w_sign}} & ~w_ext_mask);
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: selects link/load/ALU value, waits for late load
// data, handles flush of pending loads and counts retired instructions.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_stage_pipe_if.slave bus
);

    localparam int OFF_W = $clog2(XLEN / 8);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("wb_stage_pipe: XLEN must be 32 or 64");
    end

    wb_state_e         r_state;
    logic [REG_AW-1:0] r_pend_rd;
    logic [2:0]        r_pend_f3;
    logic [OFF_W-1:0]  r_pend_off;
    logic              r_wb_en;
    logic [REG_AW-1:0] r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_idle;
    logic              w_accept;
    logic              w_load_wait;
    logic [2:0]        w_ext_f3;
    logic [OFF_W-1:0]  w_ext_off;
    logic [XLEN-1:0]   w_ext_data;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_done;
    logic [REG_AW-1:0] w_done_rd;
    logic [XLEN-1:0]   w_done_data;

    // While a load is pending the extractor must see the latched size/offset,
    // not whatever the MEM stage is presenting now.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_ext_f3  = w_idle ? bus.in_funct3  : r_pend_f3;
    assign w_ext_off = w_idle ? bus.in_addr_lo : r_pend_off;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .i_raw    (bus.mem_rsp_data),
        .i_funct3 (w_ext_f3),
        .i_offset (w_ext_off),
        .o_data   (w_ext_data)
    );

    assign w_accept    = bus.in_valid & w_idle & ~bus.flush;
    assign w_load_wait = bus.in_mem_read & ~bus.in_jump & ~bus.mem_rsp_valid;
    assign w_sel_data  = bus.in_jump     ? bus.in_pc_incre :
                         bus.in_mem_read ? w_ext_data      : bus.in_alu_result;

    assign w_done      = (w_accept & ~w_load_wait) |
                         ((r_state == ST_WAIT_MEM) & ~bus.flush & bus.mem_rsp_valid);
    assign w_done_rd   = w_idle ? bus.in_rd  : r_pend_rd;
    assign w_done_data = w_idle ? w_sel_data : w_ext_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pend_rd    <= '0;
            r_pend_f3    <= '0;
            r_pend_off   <= '0;
            r_wb_en      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_wb_en <= 1'b0;
            if (w_done) begin
                r_wb_en      <= |w_done_rd;
                r_wb_rd      <= w_done_rd;
                r_wb_data    <= w_done_data;
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_load_wait) begin
                        r_pend_rd  <= bus.in_rd;
                        r_pend_f3  <= bus.in_funct3;
                        r_pend_off <= bus.in_addr_lo;
                        r_state    <= ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    // A flushed load still owes us a response unless it arrives now.
                    if (bus.flush)              r_state <= bus.mem_rsp_valid ? ST_IDLE : ST_DRAIN;
                    else if (bus.mem_rsp_valid) r_state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (bus.mem_rsp_valid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_idle;
    assign bus.wb_en      = r_wb_en;
    assign bus.wb_rd      = r_wb_rd;
    assign bus.wb_data    = r_wb_data;
    assign bus.retire_cnt = r_retire_cnt;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: drivers push expected writebacks into a queue,
// a negedge monitor pops and compares on every retire-count step.
module tb_wb_stage_pipe;
  import wb_stage_pipe_pkg::*;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 64;
  localparam int EXP_W  = 1 + REG_AW + XLEN + CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_pipe_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  wb_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt  = '0;
  logic [CNT_W-1:0] prev_cnt = '0;
  logic [EXP_W-1:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_mem_read   = 1'b0;
    bus.in_jump       = 1'b0;
    bus.in_funct3     = 3'b000;
    bus.in_addr_lo    = '0;
    bus.in_rd         = '0;
    bus.in_alu_result = '0;
    bus.in_pc_incre   = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic push_exp(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
    exp_cnt = exp_cnt + 1'b1;
    exp_q.push_back({(rd != '0), rd, data, exp_cnt});
  endtask

  // One instruction held valid for a single cycle; completes unless it is a late load.
  task automatic op(input logic jump, input logic mr, input logic [2:0] f3,
                    input logic [2:0] off, input logic [REG_AW-1:0] rd,
                    input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc,
                    input logic rsp, input logic [XLEN-1:0] raw,
                    input logic [XLEN-1:0] exp_data);
    @(posedge clk); #1;
    bus.in_valid      = 1'b1;
    bus.in_jump       = jump;
    bus.in_mem_read   = mr;
    bus.in_funct3     = f3;
    bus.in_addr_lo    = off;
    bus.in_rd         = rd;
    bus.in_alu_result = alu;
    bus.in_pc_incre   = pc;
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_data  = raw;
    if (jump || !mr || rsp) push_exp(rd, exp_data);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Monitor: every retire-count step is one completion to check against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cnt = '0;
    end else if (bus.retire_cnt !== prev_cnt) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got cnt 0x%0h expected no completion", bus.retire_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_en",      bus.wb_en,      mon_e[EXP_W-1]);
        chk("wb_rd",      bus.wb_rd,      mon_e[EXP_W-2 -: REG_AW]);
        chk("wb_data",    bus.wb_data,    mon_e[XLEN+CNT_W-1 -: XLEN]);
        chk("retire_cnt", bus.retire_cnt, mon_e[CNT_W-1:0]);
      end
      prev_cnt = bus.retire_cnt;
    end else begin
      chk("idle_wb_en", bus.wb_en, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_en",  bus.wb_en, 0);
    chk("rst_wb_rd",  bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_cnt",    bus.retire_cnt, 0);
    chk("rst_ready",  bus.in_ready, 1);
    chk("rst_state",  bus.dbg_state, ST_IDLE);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // ALU op, then jal with mem_read also set (link value wins, no wait)
    op(0, 0, F3_LB, 0, 5, 64'h1234, 64'h0, 0, 64'h0, 64'h1234);
    op(1, 1, F3_LW, 0, 1, 64'hDEAD, 64'h8000_0008, 0, 64'h0, 64'h8000_0008);
    @(negedge clk);
    chk("jal_no_wait_ready", bus.in_ready, 1);

    // Loads with data in the accept cycle
    op(0, 1, F3_LB,  3, 2,  0, 0, 1, 64'h0000_0000_FF00_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    op(0, 1, F3_LBU, 3, 3,  0, 0, 1, 64'h0000_0000_FF00_0000, 64'h0000_0000_0000_00FF);
    op(0, 1, F3_LH,  3, 4,  0, 0, 1, 64'h0000_0000_FF00_0000, 64'hFFFF_FFFF_FFFF_FF00);
    op(0, 1, F3_LW,  4, 6,  0, 0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    op(0, 1, F3_LWU, 5, 6,  0, 0, 1, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
    op(0, 1, F3_LD,  5, 8,  0, 0, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    op(0, 1, F3_LHU, 7, 10, 0, 0, 1, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
    op(0, 1, 3'b111, 2, 11, 0, 0, 1, 64'hCAFE_BABE_1234_5678, 64'hCAFE_BABE_1234_5678);
    op(0, 1, F3_LH,  1, 12, 0, 0, 1, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_7FFF);

    // Late load: response three cycles after accept; a competing ALU op is held off
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_funct3 = F3_LW;
    bus.in_addr_lo = 3'd4; bus.in_rd = 5'd7;
    @(posedge clk); #1;
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_rd = 5'd13; bus.in_alu_result = 64'h5555;
    bus.in_funct3 = F3_LBU; bus.in_addr_lo = 3'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ready_low", bus.in_ready, 0);
      chk("late_state", bus.dbg_state, ST_WAIT_MEM);
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h8765_4321_0000_0000;
    push_exp(5'd7, 64'hFFFF_FFFF_8765_4321);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("late_ready_back", bus.in_ready, 1);

    // Flush while waiting, response two cycles later -> drained, nothing retired
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_funct3 = F3_LD; bus.in_rd = 5'd14;
    @(posedge clk); #1;
    idle_inputs();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_state", bus.dbg_state, ST_WAIT_MEM);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_state", bus.dbg_state, ST_DRAIN);
    chk("drain_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("drain_hold_state", bus.dbg_state, ST_DRAIN);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("drain_exit_state", bus.dbg_state, ST_IDLE);
    chk("drain_cnt", bus.retire_cnt, exp_cnt);

    // Flush together with the response in WAIT_MEM -> straight back to IDLE
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_funct3 = F3_LW; bus.in_rd = 5'd15;
    @(posedge clk); #1;
    idle_inputs();
    bus.flush = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 64'h99;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("flush_rsp_state", bus.dbg_state, ST_IDLE);

    // Flush in IDLE drops the input; stray response in IDLE is ignored
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_rd = 5'd16; bus.in_alu_result = 64'h66; bus.flush = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 64'h77;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("idle_flush_cnt", bus.retire_cnt, exp_cnt);
    chk("stray_rsp_state", bus.dbg_state, ST_IDLE);

    // rd=0 still retires but never writes
    op(0, 0, F3_LB, 0, 0, 64'h77, 64'h0, 0, 64'h0, 64'h77);
    op(0, 1, F3_LBU, 1, 0, 0, 0, 1, 64'h0000_0000_0000_AB00, 64'hAB);
    op(0, 0, F3_LB, 0, 9, 64'hAAAA, 64'h0, 0, 64'h0, 64'hAAAA);

    // Asynchronous reset in the middle of WAIT_MEM
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_funct3 = F3_LW; bus.in_rd = 5'd17;
    @(posedge clk); #1;
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wb_en",   bus.wb_en, 0);
    chk("arst_wb_rd",   bus.wb_rd, 0);
    chk("arst_wb_data", bus.wb_data, 0);
    chk("arst_cnt",     bus.retire_cnt, 0);
    chk("arst_ready",   bus.in_ready, 1);
    chk("arst_state",   bus.dbg_state, ST_IDLE);
    exp_cnt = '0;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    op(0, 0, F3_LB, 0, 18, 64'h42, 64'h0, 0, 64'h0, 64'h42);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
